// File: rtl/axis_rate_arb.sv
// Frame round-robin arbiter sharing one rate limiter; loads the granted source's rate before its first beat.
// Latency: grant in IDLE, rate load in SETUP, first beat 2 cycles after request; beats then follow m_axis_tready combinationally.
module axis_rate_arb #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    localparam int SEL_W     = $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_axis_tvalid,
    output logic [S_COUNT-1:0]               s_axis_tready,
    input  logic [S_COUNT-1:0]               s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    input  logic                             cfg_wr_en,
    input  logic [SEL_W-1:0]                 cfg_wr_sel,
    input  logic [9:0]                       cfg_wr_num,
    input  logic [9:0]                       cfg_wr_denom,
    input  logic                             cfg_wr_by_frame,
    input  logic                             cfg_wr_enable,
    output logic                             cfg_err,
    output logic [9:0]                       rate_num,
    output logic [9:0]                       rate_denom,
    output logic                             rate_by_frame,
    output logic                             grant_valid,
    output logic [SEL_W-1:0]                 grant_index
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [9:0]         num_q   [S_COUNT];
    logic [9:0]         denom_q [S_COUNT];
    logic [S_COUNT-1:0] byf_q, en_q;
    logic [9:0]         rate_num_q, rate_num_d;
    logic [9:0]         rate_denom_q, rate_denom_d;
    logic               rate_byf_q, rate_byf_d;
    logic               err_q;
    logic               wr_ok, sel_ok;
    logic               found;
    logic [SEL_W-1:0]   winner, idx;

    assign wr_ok  = (cfg_wr_num != 10'd0) && (cfg_wr_num <= cfg_wr_denom);
    assign sel_ok = {1'b0, cfg_wr_sel} < (SEL_W + 1)'(S_COUNT);

    // Round-robin search starting just after the last completed grant.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        idx    = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            idx = SEL_W'((int'(last_q) + k) % S_COUNT);
            if (!found && s_axis_tvalid[idx] && en_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        rate_num_d   = rate_num_q;
        rate_denom_d = rate_denom_q;
        rate_byf_d   = rate_byf_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                rate_num_d   = num_q[grant_q];
                rate_denom_d = denom_q[grant_q];
                rate_byf_d   = byf_q[grant_q];
                state_d      = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (SEL_W'(i) == grant_q) begin
                m_axis_tdata = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                m_axis_tuser = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                m_axis_tlast = s_axis_tlast[i];
            end
        end
        if (state_q == ST_ACTIVE) begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_q       <= SEL_W'(S_COUNT - 1);
            rate_num_q   <= 10'd1;
            rate_denom_q <= 10'd1;
            rate_byf_q   <= 1'b0;
            err_q        <= 1'b0;
            byf_q        <= '0;
            en_q         <= '1;
            for (int i = 0; i < S_COUNT; i++) begin
                num_q[i]   <= 10'd1;
                denom_q[i] <= 10'd1;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            rate_num_q   <= rate_num_d;
            rate_denom_q <= rate_denom_d;
            rate_byf_q   <= rate_byf_d;
            err_q        <= cfg_wr_en && !wr_ok;
            // Table-only update: the limiter sees it at the entry's next SETUP.
            if (cfg_wr_en && wr_ok && sel_ok) begin
                num_q[cfg_wr_sel]   <= cfg_wr_num;
                denom_q[cfg_wr_sel] <= cfg_wr_denom;
                byf_q[cfg_wr_sel]   <= cfg_wr_by_frame;
                en_q[cfg_wr_sel]    <= cfg_wr_enable;
            end
        end
    end

    assign cfg_err       = err_q;
    assign rate_num      = rate_num_q;
    assign rate_denom    = rate_denom_q;
    assign rate_by_frame = rate_byf_q;
    assign grant_valid   = (state_q != ST_IDLE);
    assign grant_index   = grant_q;

endmodule

// File: tb/tb_axis_rate_arb.sv
// Bench for axis_rate_arb: per-source beat FIFOs drive the sources, an expected-beat queue checks the muxed stream.
module tb_axis_rate_arb;
    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 1;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [S*DW-1:0]   s_tdata;
    logic [S*KW-1:0]   s_tkeep;
    logic [S-1:0]      s_tvalid, s_tready, s_tlast;
    logic [S*UW-1:0]   s_tuser;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid, m_tready, m_tlast;
    logic [UW-1:0]     m_tuser;
    logic              cfg_wr_en, cfg_wr_by_frame, cfg_wr_enable, cfg_err;
    logic [IW-1:0]     cfg_wr_sel;
    logic [9:0]        cfg_wr_num, cfg_wr_denom;
    logic [9:0]        rate_num, rate_denom;
    logic              rate_by_frame, grant_valid;
    logic [IW-1:0]     grant_index;

    axis_rate_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_num(cfg_wr_num),
        .cfg_wr_denom(cfg_wr_denom), .cfg_wr_by_frame(cfg_wr_by_frame),
        .cfg_wr_enable(cfg_wr_enable), .cfg_err(cfg_err),
        .rate_num(rate_num), .rate_denom(rate_denom), .rate_by_frame(rate_by_frame),
        .grant_valid(grant_valid), .grant_index(grant_index)
    );

    typedef struct {
        logic [1:0] src;
        logic [7:0] dat;
        logic       last;
        logic       first;
        logic [9:0] num;
        logic [9:0] den;
        logic       byf;
    } exp_t;

    typedef struct {
        logic [1:0] sel;
        logic [9:0] num;
        logic [9:0] den;
        logic       byf;
        logic       en;
        logic       err;
    } cfg_vec_t;

    exp_t       exp_q[$];
    logic [8:0] smem [S][64];
    int         head [S];
    int         tail [S];
    int         checks = 0, failures = 0;
    int         cyc = 0, last_cyc = -1, prev_cyc = -1, beats_seen = 0;
    bit         gap_chk = 1'b0, bp_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive();
        m_tready = bp_mode ? cyc[0] : 1'b1;
        for (int i = 0; i < S; i++) begin
            logic [8:0] b;
            b = smem[i][head[i] % 64];
            s_tvalid[i]         = (head[i] != tail[i]);
            s_tdata[i*DW +: DW] = b[7:0];
            s_tlast[i]          = b[8];
            s_tkeep[i]          = 1'b1;
            s_tuser[i]          = ^b[7:0];
        end
    endtask

    task automatic monitor(output logic [S-1:0] hs);
        logic [S-1:0] hs_exp;
        exp_t         e;
        hs     = s_tvalid & s_tready;
        hs_exp = '0;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data %0h from grant %0d, expected no beat", m_tdata, grant_index);
            end else begin
                e = exp_q.pop_front();
                hs_exp[e.src] = 1'b1;
                check("beat_data", {grant_index, m_tdata, m_tlast, m_tuser, m_tkeep},
                      {e.src, e.dat, e.last, ^e.dat, 1'b1});
                check("beat_rate", {rate_num, rate_denom, rate_by_frame}, {e.num, e.den, e.byf});
                if (gap_chk && e.first) check("frame_gap", cyc - last_cyc, 3);
                if (gap_chk && !e.first) check("beat_contig", cyc - prev_cyc, 1);
                if (e.last) last_cyc = cyc;
                prev_cyc = cyc;
                beats_seen++;
            end
        end
        check("src_ready", hs, hs_exp);
    endtask

    task automatic step();
        logic [S-1:0] hs;
        drive();
        #1;
        monitor(hs);
        @(posedge clk);
        #1;
        for (int i = 0; i < S; i++) if (hs[i]) head[i]++;
        cfg_wr_en = 1'b0;
        cyc++;
        drive();
    endtask

    task automatic add_frame(input int src, input int fid, input int len, input logic [9:0] num,
                             input logic [9:0] den, input logic byf, input bit to_src, input bit to_exp);
        for (int b = 0; b < len; b++) begin
            exp_t       e;
            logic [7:0] d;
            d = {2'(src), 3'(fid), 3'(b)};
            if (to_src) begin
                smem[src][tail[src] % 64] = {(b == len - 1), d};
                tail[src]++;
            end
            if (to_exp) begin
                e.src = 2'(src); e.dat = d; e.last = (b == len - 1); e.first = (b == 0);
                e.num = num; e.den = den; e.byf = byf;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [9:0] num, input logic [9:0] den,
                             input logic byf, input logic en);
        cfg_wr_sel = sel; cfg_wr_num = num; cfg_wr_denom = den;
        cfg_wr_by_frame = byf; cfg_wr_enable = en; cfg_wr_en = 1'b1;
        step();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(name, (n < budget), 1'b1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        int n = 0;
        while (beats_seen < target && n < budget) begin
            step();
            n++;
        end
        check(name, (n < budget), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        cfg_vec_t cv[5];
        cv[0] = '{2'd1, 10'd1,   10'd4,   1'b0, 1'b1, 1'b0};
        cv[1] = '{2'd2, 10'd3,   10'd3,   1'b1, 1'b1, 1'b0};
        cv[2] = '{2'd3, 10'd0,   10'd4,   1'b1, 1'b0, 1'b1};
        cv[3] = '{2'd3, 10'd5,   10'd4,   1'b1, 1'b0, 1'b1};
        cv[4] = '{2'd3, 10'd600, 10'd512, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < S; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rst_n = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_sel = '0; cfg_wr_num = '0; cfg_wr_denom = '0;
        cfg_wr_by_frame = 1'b0; cfg_wr_enable = 1'b0;
        drive();
        step();
        step();
        #1;
        check("rst_rate", {rate_num, rate_denom, rate_by_frame}, {10'd1, 10'd1, 1'b0});
        check("rst_tready", s_tready, 4'b0000);
        check("rst_grant", {grant_valid, grant_index, m_tvalid, cfg_err}, 5'b0);
        rst_n = 1'b1;
        step();

        // Round robin with continuous offers; last_cyc = cyc-1 makes the first frame's
        // request-to-first-beat latency check as 2 cycles through the same gap check.
        gap_chk  = 1'b1;
        last_cyc = cyc - 1;
        add_frame(0, 0, 4, 10'd1, 10'd1, 1'b0, 1, 1);
        add_frame(1, 0, 4, 10'd1, 10'd1, 1'b0, 1, 1);
        add_frame(2, 0, 4, 10'd1, 10'd1, 1'b0, 1, 1);
        add_frame(3, 0, 4, 10'd1, 10'd1, 1'b0, 1, 1);
        add_frame(0, 1, 4, 10'd1, 10'd1, 1'b0, 1, 1);
        wait_drain(100, "rr_drain");
        gap_chk = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cfg_write(cv[i].sel, cv[i].num, cv[i].den, cv[i].byf, cv[i].en);
            #1;
            check("cfg_err_pulse", cfg_err, cv[i].err);
            step();
            #1;
            check("cfg_err_clear", cfg_err, 1'b0);
        end

        bp_mode = 1'b1;
        add_frame(1, 2, 3, 10'd1, 10'd4, 1'b0, 1, 1);
        add_frame(2, 2, 3, 10'd3, 10'd3, 1'b1, 1, 1);
        add_frame(3, 2, 3, 10'd1, 10'd1, 1'b0, 1, 1);
        wait_drain(100, "rate_drain");
        bp_mode = 1'b0;

        // Disable and retune source 0 mid-frame: its frame finishes at the old rate.
        beats_seen = 0;
        add_frame(0, 3, 6, 10'd1, 10'd1, 1'b0, 1, 1);
        add_frame(1, 3, 3, 10'd1, 10'd4, 1'b0, 1, 1);
        add_frame(0, 4, 3, 10'd2, 10'd8, 1'b0, 1, 0);
        wait_beats(2, 50, "mid_reach");
        cfg_write(2'd0, 10'd2, 10'd8, 1'b0, 1'b0);
        wait_drain(100, "dis_drain");
        for (int i = 0; i < 8; i++) step();
        #1;
        check("skip_disabled", grant_valid, 1'b0);
        add_frame(3, 4, 3, 10'd1, 10'd1, 1'b0, 1, 1);
        add_frame(0, 4, 3, 10'd2, 10'd8, 1'b0, 0, 1);
        cfg_write(2'd0, 10'd2, 10'd8, 1'b0, 1'b1);
        wait_drain(100, "reen_drain");

        // Write landing in the SETUP cycle loads the old entry.
        add_frame(1, 5, 2, 10'd1, 10'd4, 1'b0, 1, 1);
        step();
        cfg_write(2'd1, 10'd1, 10'd2, 1'b0, 1'b1);
        wait_drain(50, "setup_wr_drain");
        add_frame(1, 6, 2, 10'd1, 10'd2, 1'b0, 1, 1);
        wait_drain(50, "setup_wr_next");

        // Reset on beat 2 of source 1's 6-beat frame, after source 0 held the last grant.
        beats_seen = 0;
        add_frame(0, 7, 2, 10'd2, 10'd8, 1'b0, 1, 1);
        add_frame(1, 7, 6, 10'd1, 10'd2, 1'b0, 1, 1);
        wait_beats(4, 50, "rst_reach");
        rst_n = 1'b0;
        step();
        #1;
        check("midrst_tready", s_tready, 4'b0000);
        check("midrst_state", {grant_valid, m_tvalid}, 2'b00);
        check("midrst_rate", {rate_num, rate_denom}, {10'd1, 10'd1});
        exp_q.delete();
        for (int i = 0; i < S; i++) head[i] = tail[i];
        rst_n = 1'b1;
        add_frame(0, 0, 2, 10'd1, 10'd1, 1'b0, 1, 1);
        add_frame(1, 0, 2, 10'd1, 10'd1, 1'b0, 1, 1);
        wait_drain(50, "post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_rate_arb.md
# axis_rate_arb

Frame-level round-robin arbiter and rate sequencer that shares one `axis_rate_limit` instance among S_COUNT AXI-Stream sources. It grants one source per frame and muxes that source's stream onto the limiter's input. Before any beat of the frame passes, it drives the limiter's `rate_num`, `rate_denom` and `rate_by_frame` from a per-source configuration table. The block sits directly upstream of the limiter; its rate outputs connect straight to the limiter's configuration inputs.

## Interface
- `S_COUNT`, 4, number of sources (2..16)
- `DATA_WIDTH`, 8, tdata width per source
- `KEEP_WIDTH`, DATA_WIDTH/8, tkeep width per source
- `USER_WIDTH`, 1, tuser width per source
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `s_axis_tdata`  in  S_COUNT*DATA_WIDTH  packed source data; source i at slice i
- `s_axis_tkeep`  in  S_COUNT*KEEP_WIDTH  packed tkeep
- `s_axis_tvalid`  in  S_COUNT  per-source valid
- `s_axis_tready`  out  S_COUNT  per-source ready
- `s_axis_tlast`  in  S_COUNT  per-source last
- `s_axis_tuser`  in  S_COUNT*USER_WIDTH  packed tuser
- `m_axis_tdata/tkeep/tvalid/tlast/tuser`  out  as source slice  muxed stream to limiter
- `m_axis_tready`  in  1  limiter ready
- `cfg_wr_en`  in  1  table write strobe
- `cfg_wr_sel`  in  $clog2(S_COUNT)  table entry index
- `cfg_wr_num`  in  10  rate numerator
- `cfg_wr_denom`  in  10  rate denominator
- `cfg_wr_by_frame`  in  1  rate-by-frame flag
- `cfg_wr_enable`  in  1  source enable flag
- `cfg_err`  out  1  one-cycle pulse when a write is rejected
- `rate_num`  out  10  to limiter
- `rate_denom`  out  10  to limiter
- `rate_by_frame`  out  1  to limiter
- `grant_valid`  out  1  high in SETUP and ACTIVE
- `grant_index`  out  $clog2(S_COUNT)  currently granted source

## Operation
- Config table: S_COUNT entries of {num, denom, by_frame, enable}.
  - Reset value of every entry: num=1, denom=1, by_frame=0, enable=1 (full rate).
- Config writes:
  - A write with `cfg_wr_num`==0 or `cfg_wr_num`>`cfg_wr_denom` (unsigned 10-bit compare) is ignored. `cfg_err` pulses high the next cycle.
  - A valid write updates the table entry only. The rate outputs are not touched until the next SETUP.
  - Writing the entry of the active source therefore takes effect at the next frame it is granted.
- FSM states:
  - IDLE: all `s_axis_tready`=0, `m_axis_tvalid`=0. Find the eligible sources (tvalid=1 and enable=1). Search from `last_grant`+1 upward, wrapping modulo S_COUNT; the first eligible source wins. On a winner: latch `grant_index`, go to SETUP. With no eligible source, stay in IDLE.
  - SETUP (exactly 1 cycle): load `rate_num/rate_denom/rate_by_frame` from the granted entry; no transfers; go to ACTIVE.
  - ACTIVE:
    - Combinational mux: `m_axis_*` = granted source slice.
    - `s_axis_tready[grant]` = `m_axis_tready`; all other readies 0.
    - On a handshake with tlast=1: set `last_grant`=grant, go to IDLE.
- Disabling the active source (write enable=0) does not abort the current frame. The source is skipped from the next arbitration.
- Rate outputs hold their last loaded value between frames.
- Reset:
  - State returns to IDLE from any state, including mid-frame; the partial frame is abandoned.
  - Reset values: `last_grant`=S_COUNT-1 (so source 0 has first priority), `grant_index`=0, `grant_valid`=0, `s_axis_tready`=0, `m_axis_tvalid`=0.
  - Rate outputs reset to num=1, denom=1, by_frame=0; `cfg_err`=0.

## Timing
- Request to first data:
  - A source asserting tvalid in an IDLE cycle is granted that cycle.
  - Rate outputs are updated at the end of SETUP.
  - The earliest beat transfer is at cycle +2.
- Frame-to-frame gap: the tlast handshake cycle is followed by one IDLE cycle and one SETUP cycle. The next frame's first beat can transfer no earlier than 3 cycles after tlast.
- Rate outputs are stable for every cycle of ACTIVE and change only on the SETUP→ACTIVE edge.
- Within ACTIVE the path from `m_axis_tready` to `s_axis_tready` is combinational, so the block adds no extra buffering or latency per beat.
- Simultaneous events:
  - A `cfg_wr_en` in the same cycle as SETUP loads the old table value. The new value is used from the following frame.
  - When several sources become eligible together, the round-robin order above decides.

## Test plan
- Reset defaults: after `rst_n` low for 2 cycles, require `rate_num`=1, `rate_denom`=1, `rate_by_frame`=0, all `s_axis_tready`=0, `grant_valid`=0.
- Round-robin: sources 0,1,2,3 each offer continuous 4-beat frames → grant order 0,1,2,3,0. Each frame's beats stay contiguous and unmixed, and there is a 2-cycle bubble after every tlast.
- Per-source rate:
  - Program entry 1 as num=1, denom=4, and entry 2 as num=3, denom=3.
  - Source 1 frame → rate outputs 1/4 in ACTIVE; source 2 frame → 3/3.
  - Limiter output spacing follows these rates.
- Rejected writes:
  - num=0 → `cfg_err` pulses once; the entry is unchanged.
  - num=5, denom=4 → `cfg_err` pulses; the entry is unchanged.
- Enable and mid-frame config:
  - Disable source 0 during its own frame → the frame completes, and source 0 is skipped afterwards.
  - Re-enable source 0 → it is granted again in round-robin order.
  - Write entry 0 num=2, denom=8 during its frame → the new rate appears only at its next SETUP.
- Reset mid-frame: drop `rst_n` on beat 2 of a 6-beat frame → the next cycle all readies are 0 and state is IDLE. After release, source 0 wins if it is requesting.
